motor_driver_multi: RTL and testbench
=====================================

# motor_driver_multi

Parametrised multi-channel successor to the single-axis TMC-style driver block. It does three things:
- Runs a configurable init-word sequence over one shared SPI master (mode 3, 40-bit frames) into N_CH driver chips, each with its own chip select.
- Properly waits for each transfer to complete and captures each chip's status byte from the reply.
- Generates one gated step pulse train per channel.

It sits between the motion-control logic (which supplies step periods and enables) and the driver chips' SPI and STEP pins.

## Interface
- N_CH, 2: number of driver channels / chip selects.
- N_INIT, 6: number of 40-bit init words sent to every channel.
- DIV_W, 32: width of each step half-period value.
- SPI_HALF, 4: clk_in cycles per SPI clock half-period (≥1).
- GAP_CYCLES, 8: minimum clk_in cycles with all cs_n high between frames (≥1).

- clk_in  in  1  system clock.
- reset_n_in  in  1  reset, asynchronous, active-low.
- init_table_in  in  N_INIT*40  init words; word i = bits [i*40+39 : i*40]; sent in order i=0..N_INIT-1.
- start_in  in  1  re-run full init sequence; sampled only in DONE.
- serial_in  in  1  SPI MISO.
- clk_out  out  1  SPI SCK, idles high.
- serial_out  out  1  SPI MOSI.
- cs_n_out  out  N_CH  per-channel chip select, active-low, one-hot-low or all high.
- busy_out  out  1  high while the sequence runs.
- init_done_out  out  1  high in DONE.
- status_out  out  N_CH*8  channel c status = reply bits [39:32] of last frame to c.
- step_enable_in  in  N_CH  per-channel step enable.
- period_in  in  N_CH*DIV_W  channel c step half-period minus one.
- step_out  out  N_CH  per-channel STEP pin.

## Operation
- Reset values:
  - clk_out=1, serial_out=0, cs_n_out=all 1, busy_out=0, init_done_out=0, status_out=0, step_out=0.
  - FSM=LOAD, ch=0, idx=0.
- FSM states: LOAD, XFER, GAP, DONE.
  - LOAD, 1 cycle:
    - tx shift reg <= word idx.
    - cs_n_out[ch] <= 0; busy_out=1.
    - -> XFER.
  - XFER:
    - Lead-in: wait SPI_HALF cycles.
    - Then 40 bits, MSB first; per bit:
      - clk_out low for SPI_HALF cycles, serial_out = current tx MSB, driven on the falling edge.
      - clk_out high for SPI_HALF cycles; serial_in shifted into rx on the rising edge.
    - After bit 39: hold SPI_HALF cycles with clk_out=1, then cs_n_out[ch] <= 1, status[ch] <= rx[39:32] → GAP.
  - GAP: count GAP_CYCLES, then:
    - If idx<N_INIT-1: idx++, -> LOAD.
    - Else if ch<N_CH-1: idx=0, ch++, -> LOAD.
    - Else -> DONE.
  - DONE:
    - busy_out=0, init_done_out=1, serial_out=0.
    - start_in=1 -> ch=0, idx=0, init_done_out<=0, -> LOAD.
- start_in outside DONE: ignored, not queued.
- init_table_in is sampled only at LOAD. Changes mid-frame do not affect the current frame.
- Step generator, channel c:
  - Gate: active = step_enable_in[c] & init_done_out.
  - Inactive: counter=0, step_out[c]=0 on the next cycle.
  - Active: counter increments. When counter==period_in[c], step_out[c] toggles and counter clears. Frequency = f_clk / (2*(period+1)).
  - period_in change takes effect at the next compare; no glitch. If the new period is below the current count, the counter runs on and wraps at 2^DIV_W.
  - Re-init (start_in) drops init_done_out, so all step_out are forced low during the sequence.

## Timing
- cs_n low duration per frame = (1 + 80 + 1)*SPI_HALF cycles, counted from the first cycle cs_n is low.
- Frame-to-frame cs_n high ≥ GAP_CYCLES + 1 cycles (GAP + LOAD).
- Total sequence from reset release to init_done_out=1:
  - N_CH*N_INIT*(82*SPI_HALF + GAP_CYCLES + 1) cycles.
  - ±1 for the first-cycle LOAD registration.
- status_out[c] updates in the same cycle cs_n_out[c] rises.
- step_out registered: first toggle occurs period+1 cycles after the gate goes active.
- Reset mid-frame:
  - All outputs return to reset values immediately (async).
  - The sequence restarts from ch=0, idx=0 after release. No partial frame resumes.
- Simultaneous start_in and reset: reset wins.

## Test plan
- Reset, N_CH=2, N_INIT=2, SPI_HALF=2, GAP_CYCLES=4, words 0xEC000100C3, 0x9000061F0A -> four frames: ch0 w0, ch0 w1, ch1 w0, ch1 w1. Decoded MOSI bytes match MSB first; cs_n low 164 cycles each; gap ≥5; init_done_out high after ~4*169 cycles.
- MISO model returns 0xA5 then 0x3C as top byte for ch1's two frames -> status_out[15:8]=0xA5 after frame 3, 0x3C after frame 4; status_out[7:0] holds ch0's last reply.
- After done, step_enable_in=2'b01, period ch0=3 -> step_out[0] toggles every 4 cycles (period 8); step_out[1] stays 0. Change period to 1 mid-run -> toggles every 2 cycles from the next compare.
- Pulse start_in during busy -> ignored, total frame count unchanged. Pulse in DONE -> init_done_out drops next cycle, all step_out go 0, full sequence repeats.
- Assert reset_n_in mid-bit 20 of frame 2 -> cs_n all 1, clk_out 1, status 0 immediately. After release, the first frame is ch0 w0.
- step_enable_in high before init_done_out -> step_out stays 0 until done; first toggle period+1 cycles after init_done_out rises.

Source files
------------

// File: rtl/motor_driver_multi.sv
// rtl/motor_driver_multi.sv - multi-channel driver init sequencer over shared SPI (mode 3, 40-bit) plus per-channel step generators
module motor_driver_multi #(
  parameter int N_CH       = 2,
  parameter int N_INIT     = 6,
  parameter int DIV_W      = 32,
  parameter int SPI_HALF   = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic [N_INIT*40-1:0]  init_table_in,
  input  logic                  start_in,
  input  logic                  serial_in,
  output logic                  clk_out,
  output logic                  serial_out,
  output logic [N_CH-1:0]       cs_n_out,
  output logic                  busy_out,
  output logic                  init_done_out,
  output logic [N_CH*8-1:0]     status_out,
  input  logic [N_CH-1:0]       step_enable_in,
  input  logic [N_CH*DIV_W-1:0] period_in,
  output logic [N_CH-1:0]       step_out
);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IDX_W   = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int CNT_W   = $clog2(SPI_HALF + GAP_CYCLES + 1);
  localparam int HP_LAST = 81;  // half-phases: 0 lead-in, 1..80 SCK halves, 81 hold

  typedef enum logic [1:0] {LOAD, XFER, GAP, DONE} state_t;
  state_t state, state_nxt;

  logic [CH_W-1:0]        ch;
  logic [IDX_W-1:0]       idx;
  logic [CNT_W-1:0]       cnt;
  logic [6:0]             hp;
  logic [39:0]            tx, rx;
  logic [N_CH-1:0][7:0]   status_q;
  logic                   half_end, xfer_end, gap_end, last_idx, last_ch;

  assign half_end   = (cnt == CNT_W'(SPI_HALF - 1));
  assign xfer_end   = (state == XFER) && half_end && (hp == 7'(HP_LAST));
  assign gap_end    = (state == GAP) && (cnt == CNT_W'(GAP_CYCLES - 1));
  assign last_idx   = (idx == IDX_W'(N_INIT - 1));
  assign last_ch    = (ch == CH_W'(N_CH - 1));
  assign status_out = status_q;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= LOAD;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = XFER;
      XFER:    if (xfer_end) state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = (last_idx && last_ch) ? DONE : LOAD;
      DONE:    if (start_in) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ch            <= '0;
      idx           <= '0;
      cnt           <= '0;
      hp            <= '0;
      tx            <= '0;
      rx            <= '0;
      status_q      <= '0;
      clk_out       <= 1'b1;
      serial_out    <= 1'b0;
      cs_n_out      <= '1;
      busy_out      <= 1'b0;
      init_done_out <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          tx           <= init_table_in[idx*40 +: 40];
          cs_n_out[ch] <= 1'b0;
          busy_out     <= 1'b1;
          cnt          <= '0;
          hp           <= '0;
          clk_out      <= 1'b1;
        end
        XFER: begin
          if (!half_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            hp  <= hp + 7'd1;
            if (hp == 7'(HP_LAST)) begin
              cs_n_out     <= '1;
              status_q[ch] <= rx[39:32];
            end else if (!hp[0]) begin
              // even half-phase ends: falling SCK launches the next MOSI bit, except before the hold
              if (hp != 7'(HP_LAST - 1)) begin
                clk_out    <= 1'b0;
                serial_out <= tx[39];
              end
            end else begin
              clk_out <= 1'b1;
              rx      <= {rx[38:0], serial_in};
              tx      <= {tx[38:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (!gap_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!last_idx) begin
              idx <= idx + 1'b1;
            end else if (!last_ch) begin
              idx <= '0;
              ch  <= ch + 1'b1;
            end else begin
              busy_out      <= 1'b0;
              init_done_out <= 1'b1;
              serial_out    <= 1'b0;
            end
          end
        end
        DONE: begin
          serial_out <= 1'b0;
          if (start_in) begin
            ch            <= '0;
            idx           <= '0;
            init_done_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Step generators run only once the drivers are configured.
  for (genvar c = 0; c < N_CH; c++) begin : g_step
    logic [DIV_W-1:0] step_cnt;
    logic             step_q;
    logic             active;

    assign active      = step_enable_in[c] & init_done_out;
    assign step_out[c] = step_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        step_cnt <= '0;
        step_q   <= 1'b0;
      end else if (!active) begin
        step_cnt <= '0;
        step_q   <= 1'b0;
      end else if (step_cnt == period_in[c*DIV_W +: DIV_W]) begin
        step_cnt <= '0;
        step_q   <= ~step_q;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_motor_driver_multi.sv
// tb/tb_motor_driver_multi.sv - self-checking bench for motor_driver_multi
module tb_motor_driver_multi;
  localparam int N_CH = 2, N_INIT = 2, DIV_W = 32, SPI_HALF = 2, GAP_CYCLES = 4;
  localparam int SEQ_CYC = N_CH * N_INIT * (82 * SPI_HALF + GAP_CYCLES + 1);

  logic                  clk_in = 1'b0;
  logic                  reset_n_in = 1'b0;
  logic [N_INIT*40-1:0]  init_table_in = '0;
  logic                  start_in = 1'b0;
  logic                  serial_in = 1'b0;
  logic                  clk_out, serial_out, busy_out, init_done_out;
  logic [N_CH-1:0]       cs_n_out, step_out;
  logic [N_CH*8-1:0]     status_out;
  logic [N_CH-1:0]       step_enable_in = '0;
  logic [N_CH*DIV_W-1:0] period_in = '0;

  motor_driver_multi #(
    .N_CH(N_CH), .N_INIT(N_INIT), .DIV_W(DIV_W), .SPI_HALF(SPI_HALF), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .init_table_in(init_table_in),
    .start_in(start_in), .serial_in(serial_in), .clk_out(clk_out), .serial_out(serial_out),
    .cs_n_out(cs_n_out), .busy_out(busy_out), .init_done_out(init_done_out),
    .status_out(status_out), .step_enable_in(step_enable_in), .period_in(period_in),
    .step_out(step_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int                ch;
    logic [39:0]       mosi;
    logic [39:0]       reply;
    int                low;
    int                gap;
    int                onehot;
    logic [N_CH*8-1:0] status;
  } frame_t;

  frame_t      frames[$];
  logic [39:0] miso_q[$];
  int          mon_bits = 0;
  int          tests = 0, fails = 0;
  logic [39:0] words [N_INIT];
  int          exp_ch[$];
  logic [39:0] exp_word[$];
  logic [7:0]  exp_status [N_CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic set_table();
    for (int i = 0; i < N_INIT; i++) init_table_in[i*40 +: 40] = words[i];
  endtask

  task automatic random_words();
    logic [63:0] r;
    for (int i = 0; i < N_INIT; i++) begin
      r = {$urandom(), $urandom()};
      words[i] = r[39:0];
    end
  endtask

  // Expected frame order: every init word to channel 0, then to channel 1, ...
  task automatic expect_seq();
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < N_INIT; i++) begin
        exp_ch.push_back(c);
        exp_word.push_back(words[i]);
      end
  endtask

  task automatic check_frames(input string tag);
    frame_t            f;
    logic [N_CH*8-1:0] s;
    check({tag, "_count"}, 64'(frames.size()), 64'(exp_ch.size()));
    for (int n = 0; n < exp_ch.size() && frames.size() > 0; n++) begin
      f = frames.pop_front();
      check({tag, "_ch"}, 64'(f.ch), 64'(exp_ch[n]));
      check({tag, "_mosi"}, 64'(f.mosi), 64'(exp_word[n]));
      check({tag, "_cs_low"}, 64'(f.low), 64'(82 * SPI_HALF));
      check({tag, "_onehot"}, 64'(f.onehot), 64'(1));
      if (n > 0) check({tag, "_gap"}, 64'(f.gap >= GAP_CYCLES + 1), 64'(1));
      exp_status[f.ch] = f.reply[39:32];
      for (int c = 0; c < N_CH; c++) s[c*8 +: 8] = exp_status[c];
      check({tag, "_status"}, 64'(f.status), 64'(s));
    end
    frames.delete();
    exp_ch.delete();
    exp_word.delete();
  endtask

  // SPI slave/monitor: decodes MOSI on rising SCK, drives MISO on falling SCK.
  initial begin : monitor
    logic        prev_clk;
    logic [63:0] r;
    bit          active;
    int          low, high, nd;
    frame_t      f;
    prev_clk = 1'b1;
    active = 0;
    low = 0;
    high = 0;
    nd = 0;
    forever begin
      @(negedge clk_in);
      if (!reset_n_in) begin
        active = 0;
        high = 0;
        mon_bits = 0;
        serial_in = 1'b0;
      end else if (active && (&cs_n_out)) begin
        active = 0;
        if (mon_bits == 40) begin
          f.low = low;
          f.status = status_out;
          frames.push_back(f);
        end
        high = 1;
      end else if (!active && !(&cs_n_out)) begin
        active = 1;
        for (int c = 0; c < N_CH; c++) if (!cs_n_out[c]) f.ch = c;
        f.gap = high;
        f.onehot = $countones(~cs_n_out);
        f.mosi = '0;
        if (miso_q.size() > 0) f.reply = miso_q.pop_front();
        else begin
          r = {$urandom(), $urandom()};
          f.reply = r[39:0];
        end
        low = 1;
        high = 0;
        mon_bits = 0;
        nd = 0;
      end else if (active) begin
        low++;
        if (!prev_clk && clk_out) begin
          f.mosi = {f.mosi[38:0], serial_out};
          mon_bits++;
        end
        if (prev_clk && !clk_out && nd < 40) begin
          serial_in = f.reply[39 - nd];
          nd++;
        end
      end else begin
        high++;
      end
      prev_clk = clk_out;
    end
  end

  initial begin : main
    int          cyc, p0, p1, pp, stepbad;
    bit          scr;
    logic [63:0] r;

    words[0] = 40'hEC000100C3;
    words[1] = 40'h9000061F0A;
    set_table();
    for (int c = 0; c < N_CH; c++) exp_status[c] = 8'h00;
    tick(3);
    check("rst_clk_out", 64'(clk_out), 64'(1));
    check("rst_serial_out", 64'(serial_out), 64'(0));
    check("rst_cs_n", 64'(cs_n_out), 64'(2'b11));
    check("rst_busy", 64'(busy_out), 64'(0));
    check("rst_done", 64'(init_done_out), 64'(0));
    check("rst_status", 64'(status_out), 64'(0));
    check("rst_step", 64'(step_out), 64'(0));

    // Run 1: fixed words, ch1 replies carry 0xA5 then 0x3C; start pulse while busy is ignored.
    r = {$urandom(), $urandom()};
    miso_q.push_back(r[39:0]);
    r = {$urandom(), $urandom()};
    miso_q.push_back(r[39:0]);
    r = {$urandom(), $urandom()};
    miso_q.push_back({8'hA5, r[31:0]});
    r = {$urandom(), $urandom()};
    miso_q.push_back({8'h3C, r[31:0]});
    expect_seq();
    reset_n_in = 1'b1;
    cyc = 0;
    while (!init_done_out && cyc < 3000) begin
      @(negedge clk_in);
      cyc++;
      start_in = (cyc == 300);
      if (cyc > 1 && cyc < SEQ_CYC - 1 && !busy_out) check("run1_busy", 64'(busy_out), 64'(1));
    end
    start_in = 1'b0;
    check("run1_seq_cycles", 64'(cyc >= SEQ_CYC - 1 && cyc <= SEQ_CYC + 1), 64'(1));
    check_frames("run1");
    check("run1_status_ch1", 64'(status_out[15:8]), 64'(8'h3C));
    check("run1_busy_done", 64'(busy_out), 64'(0));
    check("run1_mosi_idle", 64'(serial_out), 64'(0));
    check("run1_cs_idle", 64'(cs_n_out), 64'(2'b11));

    // Steps on channel 0 only, period 3, then period 1 right after a toggle.
    period_in = {32'd0, 32'd3};
    step_enable_in = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      check("step_p3", 64'(step_out), 64'((k / 4) % 2));
    end
    period_in = {32'd0, 32'd1};
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      check("step_p1", 64'(step_out), 64'((1 + k / 2) % 2));
    end

    // Random periods on both channels.
    for (int round = 0; round < 3; round++) begin
      step_enable_in = 2'b00;
      tick(2);
      check("step_disabled", 64'(step_out), 64'(0));
      p0 = $urandom_range(6, 0);
      p1 = $urandom_range(6, 0);
      period_in = {32'(p1), 32'(p0)};
      step_enable_in = 2'b11;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk_in);
        check("step_rand", 64'(step_out), 64'(((k / (p1 + 1)) % 2) * 2 + (k / (p0 + 1)) % 2));
      end
    end

    // Run 2: restart from DONE with random words; table changes mid-frame of the last frame.
    random_words();
    set_table();
    expect_seq();
    pp = $urandom_range(5, 1);
    period_in = {32'd0, 32'(pp)};
    step_enable_in = 2'b01;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("restart_done_drop", 64'(init_done_out), 64'(0));
    @(negedge clk_in);
    check("restart_step_low", 64'(step_out), 64'(0));
    cyc = 0;
    stepbad = 0;
    scr = 0;
    while (!init_done_out && cyc < 3000) begin
      @(negedge clk_in);
      cyc++;
      if (step_out != 0) stepbad++;
      if (!scr && frames.size() == N_CH * N_INIT - 1 && mon_bits == 10) begin
        scr = 1;
        random_words();
        set_table();
      end
    end
    check("run2_finished", 64'(cyc < 3000), 64'(1));
    check("run2_step_forced_low", 64'(stepbad), 64'(0));
    check_frames("run2");
    for (int k = 1; k <= 2 * (pp + 1) + 1; k++) begin
      @(negedge clk_in);
      check("step_after_done", 64'(step_out), 64'((k / (pp + 1)) % 2));
    end

    // Run 3: reset during bit 20 of the second frame, then a clean full sequence.
    step_enable_in = 2'b00;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    cyc = 0;
    while (!(frames.size() == 1 && mon_bits == 20 && clk_out == 1'b0) && cyc < 2000) begin
      @(negedge clk_in);
      cyc++;
    end
    check("reset_point_reached", 64'(cyc < 2000), 64'(1));
    reset_n_in = 1'b0;
    #1;
    check("midrst_cs_n", 64'(cs_n_out), 64'(2'b11));
    check("midrst_clk_out", 64'(clk_out), 64'(1));
    check("midrst_status", 64'(status_out), 64'(0));
    check("midrst_busy", 64'(busy_out), 64'(0));
    check("midrst_serial_out", 64'(serial_out), 64'(0));
    frames.delete();
    miso_q.delete();
    for (int c = 0; c < N_CH; c++) exp_status[c] = 8'h00;
    tick(3);
    expect_seq();
    reset_n_in = 1'b1;
    cyc = 0;
    while (!init_done_out && cyc < 3000) begin
      @(negedge clk_in);
      cyc++;
    end
    check("run3_seq_cycles", 64'(cyc >= SEQ_CYC - 1 && cyc <= SEQ_CYC + 1), 64'(1));
    check_frames("run3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
